alu_issue_stage: RTL

Producer side of the ALU operand/operation interface. Decodes a RISC-V RV32I instruction from the ID stage into an `alu_operation_t` opcode, selects and extends the two ALU operands, and registers them into the ID/EX boundary through a valid/ready handshake. A two-entry skid buffer keeps `in_ready` fully registered. The block sits between the register file read and the `alu`; its `opSel`, `bus_a` and `bus_b` outputs feed that ALU directly.

---
 rtl/alu_issue_stage_pkg.sv | 77 +++++++
 rtl/alu_issue_stage_decoder.sv | 105 ++++++++++
 rtl/alu_issue_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: operation and flag enums, RV32I opcodes and the
// issue record carried across the ID/EX boundary.
package definitions;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   typedef enum logic [3:0] {
      ADD,
      SUB,
      SLL,
      SLT,
      SLTU,
      XOR,
      SRL,
      SRA,
      OR,
      AND,
      FWD
   } alu_operation_t;

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } flag_t;

   localparam logic [6:0] OP      = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] LUI     = 7'b0110111;
   localparam logic [6:0] AUIPC   = 7'b0010111;
   localparam logic [6:0] LOAD    = 7'b0000011;
   localparam logic [6:0] STORE   = 7'b0100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_operation_t  opSel;
      logic [XLEN-1:0] bus_a;
      logic [XLEN-1:0] bus_b;
      logic [4:0]      rd_addr;
      flag_t           reg_wr;
      flag_t           illegal;
   } alu_issue_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } buf_state_t;

   localparam alu_issue_t ISSUE_RESET = '{
      opSel:   ADD,
      bus_a:   '0,
      bus_b:   '0,
      rd_addr: 5'd0,
      reg_wr:  LOW,
      illegal: LOW
   };

   // Operation selected by funct3 when funct7 carries no alternate form.
   function automatic alu_operation_t base_op(input logic [2:0] f3);
      alu_operation_t op;
      case (f3)
         3'b000:  op = ADD;
         3'b001:  op = SLL;
         3'b010:  op = SLT;
         3'b011:  op = SLTU;
         3'b100:  op = XOR;
         3'b101:  op = SRL;
         3'b110:  op = OR;
         default: op = AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decode: maps one instruction plus its operands onto
// the ALU operation, the two operand buses and the write-back flags.
module alu_decoder
   import definitions::*;
(
   input  logic [ILEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output alu_issue_t      issue
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign rd     = instr[11:7];
   assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u  = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
   assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

   alu_operation_t  op;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            writes;
   logic            bad;

   always_comb begin
      // NOTE: every variable is given a default before the case so that no
      // decode path leaves it unassigned and infers a latch.
      op     = ADD;
      op_a   = '0;
      op_b   = '0;
      writes = 1'b0;
      bad    = 1'b0;
      unique case (opcode)
         OP: begin
            op_a   = rs1;
            op_b   = rs2;
            writes = 1'b1;
            if (f7 == F7_BASE)                      op  = base_op(f3);
            else if (f7 == F7_ALT && f3 == 3'b000)  op  = SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)  op  = SRA;
            else                                    bad = 1'b1;
         end
         OP_IMM: begin
            op_a   = rs1;
            writes = 1'b1;
            op     = base_op(f3);
            // Shifts reuse the upper immediate bits as a funct7 qualifier.
            if (f3 == 3'b001 || f3 == 3'b101) begin
               op_b = shamt;
               if (f3 == 3'b101 && f7 == F7_ALT) op  = SRA;
               else if (f7 != F7_BASE)           bad = 1'b1;
            end else begin
               op_b = imm_i;
            end
         end
         LUI: begin
            op     = FWD;
            op_a   = imm_u;
            writes = 1'b1;
         end
         AUIPC: begin
            op_a   = pc;
            op_b   = imm_u;
            writes = 1'b1;
         end
         LOAD: begin
            op_a   = rs1;
            op_b   = imm_i;
            writes = 1'b1;
         end
         STORE: begin
            op_a = rs1;
            op_b = imm_s;
         end
         default: bad = 1'b1;
      endcase
   end

   // Illegal encodings travel on as inert ADD 0,0 so only the trap flag matters.
   always_comb begin
      issue         = ISSUE_RESET;
      issue.rd_addr = rd;
      if (bad) begin
         issue.illegal = HIGH;
      end else begin
         issue.opSel  = op;
         issue.bus_a  = op_a;
         issue.bus_b  = op_b;
         issue.reg_wr = (writes && rd != 5'd0) ? HIGH : LOW;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes the incoming instruction and holds it in a
// two-entry skid buffer so that in_ready comes straight from a flop.
module alu_issue_stage
   import definitions::*;
#(
   parameter int DATA_WIDTH  = XLEN,
   parameter int INSTR_WIDTH = ILEN
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [DATA_WIDTH-1:0]  pc,
   input  logic [DATA_WIDTH-1:0]  rs1_data,
   input  logic [DATA_WIDTH-1:0]  rs2_data,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output alu_operation_t         opSel,
   output logic [DATA_WIDTH-1:0]  bus_a,
   output logic [DATA_WIDTH-1:0]  bus_b,
   output logic [4:0]             rd_addr,
   output flag_t                  reg_wr,
   output flag_t                  illegal
);

   alu_issue_t dec_issue;

   alu_decoder u_decoder (
      .instr (instr),
      .pc    (pc),
      .rs1   (rs1_data),
      .rs2   (rs2_data),
      .issue (dec_issue)
   );

   buf_state_t state_q, state_d;
   alu_issue_t main_q, main_d;
   alu_issue_t skid_q, skid_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic       accept;
   logic       take;

   assign accept = in_valid & in_ready_q;
   assign take   = out_valid_q & out_ready;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         // NOTE: the entry registers are reset as well, because their
         // contents drive the outputs directly and must read as ADD 0,0.
         state_q     <= EMPTY;
         main_q      <= ISSUE_RESET;
         skid_q      <= ISSUE_RESET;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge regardless of statement order.
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = dec_issue;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && take) begin
                  main_d = dec_issue;
               end else if (accept) begin
                  skid_d  = dec_issue;
                  state_d = FULL;
               end else if (take) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so the only event is the skid draining.
               if (take) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign opSel     = main_q.opSel;
   assign bus_a     = main_q.bus_a;
   assign bus_b     = main_q.bus_b;
   assign rd_addr   = main_q.rd_addr;
   assign reg_wr    = main_q.reg_wr;
   assign illegal   = main_q.illegal;

endmodule
